// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, scan phase type and the sync/active delay-line record
// used by the VGA framebuffer reader.
package vga_pkg;
  typedef enum logic [1:0] {ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH} phase_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int FB_ADDR_W = 19;
  localparam int FB_PIXELS = 307200;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic border;
  } pix_ctl_t;

  localparam pix_ctl_t PIX_CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, border: 1'b0};

  function automatic phase_t decode_phase(input int count, input int act, input int fp,
                                          input int sync);
    if (count < act) return ACTIVE;
    if (count < act + fp) return FRONT_PORCH;
    if (count < act + fp + sync) return SYNC;
    return BACK_PORCH;
  endfunction
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: free-running h/v scan counters, per-axis phase decode and the
// per-frame tick that is high while the counters sit at (0,0) after a wrap.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output phase_t        h_phase,
  output phase_t        v_phase,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last;
  logic v_last;

  assign h_last = (hcount == HW'(H_TOTAL - 1));
  assign v_last = (vcount == VW'(V_TOTAL - 1));

  // Registered so the tick appears on the wrap into (0,0) but not straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_last && v_last;
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  assign h_phase = decode_phase(int'(hcount), H_ACTIVE, H_FP, H_SYNC);
  assign v_phase = decode_phase(int'(vcount), V_ACTIVE, V_FP, V_SYNC);
endmodule

// File: rtl/vga_framebuffer_reader.sv
// vga_framebuffer_reader: scans the 1-bit framebuffer out through the RAM read port and
// drives VGA sync/colour. Build option FRAME_BORDER_EN paints the outer active ring white.
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int RAM_LATENCY = 1,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [FB_ADDR_W-1:0] ram_read_address,
  input  logic                 ram_read_data,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 video_active,
  output logic                 frame_start
);
  localparam int PIPE    = RAM_LATENCY + 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          s0_border;
  pix_ctl_t      s0;
  pix_ctl_t      dly [PIPE-1];
  pix_ctl_t      tail;
  logic          lit;

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clock      (clock),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .h_phase    (h_phase),
    .v_phase    (v_phase),
    .frame_start(frame_start)
  );

`ifdef FRAME_BORDER_EN
  assign s0_border = (hcount == '0) || (hcount == HW'(H_ACTIVE - 1)) ||
                     (vcount == '0) || (vcount == VW'(V_ACTIVE - 1));
`else
  assign s0_border = 1'b0;
`endif

  assign s0 = '{hsync:  (h_phase != SYNC),
                vsync:  (v_phase != SYNC),
                active: (h_phase == ACTIVE) && (v_phase == ACTIVE),
                border: s0_border};

  // Running raster address: (0,0) restarts it, blanking holds the last visible address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_read_address <= '0;
    end else if (s0.active) begin
      if (hcount == '0 && vcount == '0)
        ram_read_address <= '0;
      else if (ram_read_address < FB_ADDR_W'(FB_PIXELS - 1))
        ram_read_address <= ram_read_address + 1'b1;
    end
  end

  // PIPE-1 stages here plus the output register keep sync aligned with RAM data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE - 1; i++) dly[i] <= PIX_CTL_IDLE;
    end else begin
      dly[0] <= s0;
      for (int i = 1; i < PIPE - 1; i++) dly[i] <= dly[i-1];
    end
  end

  assign tail = dly[PIPE-2];
  assign lit  = tail.active && (ram_read_data || tail.border);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_hsync    <= 1'b1;
      vga_vsync    <= 1'b1;
      video_active <= 1'b0;
      vga_r        <= 4'h0;
      vga_g        <= 4'h0;
      vga_b        <= 4'h0;
    end else begin
      vga_hsync    <= tail.hsync;
      vga_vsync    <= tail.vsync;
      video_active <= tail.active;
      vga_r        <= {4{lit}};
      vga_g        <= {4{lit}};
      vga_b        <= {4{lit}};
    end
  end
endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// tb_vga_framebuffer_reader: a reduced-geometry instance scanned against a random RAM image
// and a full 640x480 instance whose RAM lights only address 641.
module tb_vga_framebuffer_reader;
  typedef struct packed {int ha; int hf; int hs; int ht; int va; int vf; int vs; int fr;} geom_t;

  localparam geom_t GS = '{ha: 16, hf: 2, hs: 3, ht: 24, va: 8, vf: 2, vs: 2, fr: 360};
  localparam geom_t GF = '{ha: 640, hf: 16, hs: 96, ht: 800, va: 480, vf: 10, vs: 2, fr: 420000};
  localparam int L     = 1;
  localparam int PIPE  = L + 2;
  localparam int NPIX  = 128;
`ifdef FRAME_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic clock;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [18:0] ram_read_address;
  logic        ram_read_data;
  logic        vga_hsync, vga_vsync, video_active, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [18:0] ra_q [L];
  logic        mem [NPIX];
  bit          exp_q [$];

  logic [18:0] f_addr;
  logic        f_data, f_hsync, f_vsync, f_active, f_fs;
  logic [3:0]  f_r, f_g, f_b;
  logic [18:0] f_q;

  vga_framebuffer_reader #(
    .RAM_LATENCY(L), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clock(clock), .reset(reset), .ram_read_address(ram_read_address),
    .ram_read_data(ram_read_data), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .video_active(video_active),
    .frame_start(frame_start)
  );

  vga_framebuffer_reader dut_full (
    .clock(clock), .reset(reset), .ram_read_address(f_addr), .ram_read_data(f_data),
    .vga_hsync(f_hsync), .vga_vsync(f_vsync), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .video_active(f_active), .frame_start(f_fs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // RAM models: read data valid L clocks after the address
  always @(posedge clock) begin
    ra_q[0] <= ram_read_address;
    for (int i = 1; i < L; i++) ra_q[i] <= ra_q[i-1];
    f_q <= f_addr;
  end
  assign ram_read_data = (ra_q[L-1] < 19'(NPIX)) ? mem[ra_q[L-1][6:0]] : 1'b0;
  assign f_data        = (f_q == 19'd641);

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pix_border(int x, int y, geom_t g);
    return BORDER_ON && (x == 0 || x == g.ha - 1 || y == 0 || y == g.va - 1);
  endfunction

  // {hsync, vsync, active} on the pins after edge t: stage-0 position t-PIPE
  function automatic logic [2:0] exp_sync(int t, geom_t g);
    int c, x, y;
    c = t - PIPE;
    if (c < 0) return 3'b110;
    c = c % g.fr;
    x = c % g.ht;
    y = c / g.ht;
    return {!(x >= g.ha + g.hf && x < g.ha + g.hf + g.hs),
            !(y >= g.va + g.vf && y < g.va + g.vf + g.vs),
            (x < g.ha && y < g.va)};
  endfunction

  // Address after edge t: raster index of the last visible pixel scanned this frame
  function automatic int exp_addr(int t, geom_t g);
    int p, x, y;
    if (t == 0) return 0;
    p = (t - 1) % g.fr;
    x = p % g.ht;
    y = p / g.ht;
    if (y >= g.va) return g.va * g.ha - 1;
    if (x >= g.ha) return y * g.ha + g.ha - 1;
    return y * g.ha + x;
  endfunction

  task automatic fill();
    for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < NPIX; i++) exp_q.push_back(mem[i] | pix_border(i % GS.ha, i / GS.ha, GS));
  endtask

  task automatic wait_pos(input int pos, input string what);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 2 * GS.fr && !hit; k++) begin
      @(negedge clock);
      hit = ((cyc % GS.fr) == pos);
    end
    check({"wait_", what}, int'(hit), 1);
  endtask

  always @(negedge clock) begin : monitor
    int t, c, p;
    bit e, lit;
    logic [2:0] es;
    if (!reset) begin
      t  = cyc;
      es = exp_sync(t, GS);
      check("small_sync", int'({vga_hsync, vga_vsync, video_active}), int'(es));
      check("small_addr", int'(ram_read_address), exp_addr(t, GS));
      check("small_frame_start", int'(frame_start), int'(t > 0 && (t % GS.fr) == 0));
      if (video_active) begin
        check("small_pixel_queue_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("small_rgb", int'({vga_r, vga_g, vga_b}), e ? 32'hFFF : 0);
        end
      end else begin
        check("small_rgb_blank", int'({vga_r, vga_g, vga_b}), 0);
      end

      es = exp_sync(t, GF);
      check("full_sync", int'({f_hsync, f_vsync, f_active}), int'(es));
      check("full_addr", int'(f_addr), exp_addr(t, GF));
      check("full_frame_start", int'(f_fs), int'(t > 0 && (t % GF.fr) == 0));
      lit = 1'b0;
      if (es[0]) begin
        c   = t - PIPE;
        p   = c % GF.fr;
        lit = (p == GF.ht + 1) || pix_border(p % GF.ht, p / GF.ht, GF);
      end
      check("full_rgb", int'({f_r, f_g, f_b}), lit ? 32'hFFF : 0);
    end
  end

  task automatic check_reset_values();
    check("rst_small_ctl", int'({vga_hsync, vga_vsync, video_active, frame_start}), 'b1100);
    check("rst_small_rgb", int'({vga_r, vga_g, vga_b}), 0);
    check("rst_small_addr", int'(ram_read_address), 0);
    check("rst_full_ctl", int'({f_hsync, f_vsync, f_active, f_fs}), 'b1100);
    check("rst_full_rgb", int'({f_r, f_g, f_b}), 0);
    check("rst_full_addr", int'(f_addr), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    fill();
    repeat (3) @(negedge clock);
    #1 check_reset_values();
    #1 reset = 1'b0;
    for (int f = 0; f < 8; f++) begin
      if (f == 3) begin
        wait_pos(4 * GS.ht + 5, "mid_frame");
        #2 reset = 1'b1;
        #1 check_reset_values();
        repeat (3) @(negedge clock);
        exp_q.delete();
        fill();
        #2 reset = 1'b0;
      end
      wait_pos((GS.va + 1) * GS.ht, "vblank");
      fill();
    end
    wait_pos((GS.va + 1) * GS.ht, "final_vblank");
    check("small_pixels_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
